scr1_tcm_banked: RTL and testbench



---
 rtl/scr1_tcm_banked.sv | 144 ++++++++++++++
 tb/tb_scr1_tcm_banked.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_banked.sv
// Banked tightly-coupled memory with an instruction and a data port sharing word-interleaved
// single-port SRAM banks. Same-bank collisions are resolved by a round-robin priority flag.
module scr1_tcm_banked #(
  parameter int          NBANKS    = 2,
  parameter int          BANK_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imem_req,
  input  logic [31:0]               imem_addr,
  output logic                      imem_req_ack,
  output logic [31:0]               imem_rdata,
  output logic [1:0]                imem_resp,
  input  logic                      dmem_req,
  input  logic                      dmem_cmd,
  input  logic [1:0]                dmem_width,
  input  logic [31:0]               dmem_addr,
  input  logic [31:0]               dmem_wdata,
  output logic                      dmem_req_ack,
  output logic [31:0]               dmem_rdata,
  output logic [1:0]                dmem_resp,
  output logic [NBANKS-1:0]         sram_csb,
  output logic [NBANKS-1:0]         sram_web,
  output logic [4*NBANKS-1:0]       sram_wmask,
  output logic [BANK_AW*NBANKS-1:0] sram_addr,
  output logic [32*NBANKS-1:0]      sram_din,
  input  logic [32*NBANKS-1:0]      sram_dout
);

  localparam int          LOG2     = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int          BW       = (LOG2 > 0) ? LOG2 : 1;
  localparam logic [32:0] WIN      = 33'(NBANKS) << (BANK_AW + 2);
  localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};

  // Addresses below the base wrap to >= 2^32 in 33 bits, so one compare covers both ends.
  function automatic logic in_win(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - BASE_EXT;
    return off < WIN;
  endfunction

  function automatic logic [BW-1:0] bank_of(input logic [31:0] a);
    return (NBANKS == 1) ? '0 : BW'(a >> 2);
  endfunction

  function automatic logic [BANK_AW-1:0] word_of(input logic [31:0] a);
    return BANK_AW'(a >> (2 + LOG2));
  endfunction

  function automatic logic misaligned(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  logic [BW-1:0]      i_bank, d_bank;
  logic [BANK_AW-1:0] i_word, d_word;
  logic               i_err, d_err, conflict, i_acc, d_acc;
  logic [3:0]         d_wmask;
  logic [31:0]        d_wdata_rep;

  logic               prio_imem_reg;
  logic               i_vld_reg, i_err_reg, d_vld_reg, d_err_reg, d_rd_reg;
  logic [BW-1:0]      i_bank_reg, d_bank_reg;

  assign i_bank = bank_of(imem_addr);
  assign d_bank = bank_of(dmem_addr);
  assign i_word = word_of(imem_addr);
  assign d_word = word_of(dmem_addr);
  assign i_err  = !in_win(imem_addr) || (imem_addr[1:0] != 2'b00);
  assign d_err  = !in_win(dmem_addr) || misaligned(dmem_width, dmem_addr[1:0]);

  // Erroring requests never touch a bank, so they are kept out of arbitration.
  assign conflict     = imem_req && !i_err && dmem_req && !d_err && (i_bank == d_bank);
  assign imem_req_ack = !rst && imem_req && (!conflict || prio_imem_reg);
  assign dmem_req_ack = !rst && dmem_req && (!conflict || !prio_imem_reg);
  assign i_acc        = imem_req_ack && !i_err;
  assign d_acc        = dmem_req_ack && !d_err;

  always_comb begin
    d_wmask     = 4'b1111;
    d_wdata_rep = dmem_wdata;
    case (dmem_width)
      2'b00: begin
        d_wmask     = 4'b0001 << dmem_addr[1:0];
        d_wdata_rep = {4{dmem_wdata[7:0]}};
      end
      2'b01: begin
        d_wmask     = dmem_addr[1] ? 4'b1100 : 4'b0011;
        d_wdata_rep = {2{dmem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic i_sel, d_sel, d_wr;
      assign i_sel = i_acc && (i_bank == BW'(gi));
      assign d_sel = d_acc && (d_bank == BW'(gi));
      assign d_wr  = d_sel && dmem_cmd;
      assign sram_csb[gi]                    = !(i_sel || d_sel);
      assign sram_web[gi]                    = !d_wr;
      assign sram_wmask[4*gi +: 4]           = d_wr ? d_wmask : 4'b0000;
      assign sram_addr[BANK_AW*gi +: BANK_AW] = d_sel ? d_word : (i_sel ? i_word : '0);
      assign sram_din[32*gi +: 32]           = d_wr ? d_wdata_rep : 32'h0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_imem_reg <= 1'b0;
      i_vld_reg     <= 1'b0;
      i_err_reg     <= 1'b0;
      i_bank_reg    <= '0;
      d_vld_reg     <= 1'b0;
      d_err_reg     <= 1'b0;
      d_rd_reg      <= 1'b0;
      d_bank_reg    <= '0;
    end else begin
      if (conflict) prio_imem_reg <= !prio_imem_reg;
      i_vld_reg  <= imem_req_ack;
      i_err_reg  <= i_err;
      i_bank_reg <= i_bank;
      d_vld_reg  <= dmem_req_ack;
      d_err_reg  <= d_err;
      d_rd_reg   <= !dmem_cmd;
      d_bank_reg <= d_bank;
    end
  end

  // Response gated by rst so a request accepted just before reset reports nothing.
  assign imem_resp  = (rst || !i_vld_reg) ? 2'b00 : (i_err_reg ? 2'b10 : 2'b01);
  assign dmem_resp  = (rst || !d_vld_reg) ? 2'b00 : (d_err_reg ? 2'b10 : 2'b01);
  assign imem_rdata = (!rst && i_vld_reg && !i_err_reg) ?
                      sram_dout[32*int'(i_bank_reg) +: 32] : 32'h0;
  assign dmem_rdata = (!rst && d_vld_reg && !d_err_reg && d_rd_reg) ?
                      sram_dout[32*int'(d_bank_reg) +: 32] : 32'h0;

endmodule

// File: tb/tb_scr1_tcm_banked.sv
// Directed bench for scr1_tcm_banked: behavioural SRAM banks, a vector table of single
// transactions, and hand-written sequences for arbitration, streaming and reset.
module tb_scr1_tcm_banked;
  localparam int          NB   = 2;
  localparam int          AW   = 10;
  localparam logic [31:0] B    = 32'h0001_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req, imem_req_ack;
  logic [31:0]       imem_addr, imem_rdata;
  logic [1:0]        imem_resp;
  logic              dmem_req, dmem_cmd, dmem_req_ack;
  logic [1:0]        dmem_width, dmem_resp;
  logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
  logic [NB-1:0]     sram_csb, sram_web;
  logic [4*NB-1:0]   sram_wmask;
  logic [AW*NB-1:0]  sram_addr;
  logic [32*NB-1:0]  sram_din, sram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scr1_tcm_banked #(.NBANKS(NB), .BANK_AW(AW), .BASE_ADDR(B)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Single-port SRAM model, zero-initialised, registered read.
  logic [31:0] mem [NB][1 << AW];
  initial begin
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < (1 << AW); w++) mem[b][w] = 32'h0;
    sram_dout = '0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!sram_csb[b]) begin
        if (!sram_web[b]) begin
          for (int k = 0; k < 4; k++)
            if (sram_wmask[4*b+k])
              mem[b][sram_addr[AW*b +: AW]][8*k +: 8] <= sram_din[32*b + 8*k +: 8];
        end else begin
          sram_dout[32*b +: 32] <= mem[b][sram_addr[AW*b +: AW]];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    imem_req = 0; imem_addr = 0;
    dmem_req = 0; dmem_cmd = 0; dmem_width = 2'b10; dmem_addr = 0; dmem_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        d_req;
    logic        d_cmd;
    logic [1:0]  d_w;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic        e_dack;
    logic        e_iack;
    logic [1:0]  e_csb;
    logic [1:0]  e_dresp;
    logic [31:0] e_drdata;
    logic [1:0]  e_iresp;
    logic [31:0] e_irdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1,1,2'd2,B+32'h10,32'hDEAD_BEEF,0,32'h0,        1,0,2'b10,2'b01,32'h0,2'b00,32'h0});
    vecs.push_back('{1,0,2'd2,B+32'h10,32'h0,0,32'h0,                1,0,2'b10,2'b01,32'hDEAD_BEEF,2'b00,32'h0});
    vecs.push_back('{0,0,2'd2,32'h0,32'h0,1,B+32'h10,                0,1,2'b10,2'b00,32'h0,2'b01,32'hDEAD_BEEF});
    vecs.push_back('{1,1,2'd2,B+32'h20,32'h1122_3344,0,32'h0,        1,0,2'b10,2'b01,32'h0,2'b00,32'h0});
    vecs.push_back('{1,1,2'd0,B+32'h23,32'hFFFF_FFA5,0,32'h0,        1,0,2'b10,2'b01,32'h0,2'b00,32'h0});
    vecs.push_back('{1,0,2'd2,B+32'h20,32'h0,0,32'h0,                1,0,2'b10,2'b01,32'hA522_3344,2'b00,32'h0});
    vecs.push_back('{1,1,2'd1,B+32'h22,32'hFFFF_7788,0,32'h0,        1,0,2'b10,2'b01,32'h0,2'b00,32'h0});
    vecs.push_back('{1,0,2'd2,B+32'h20,32'h0,0,32'h0,                1,0,2'b10,2'b01,32'h7788_3344,2'b00,32'h0});
    vecs.push_back('{1,0,2'd2,B+32'h2,32'h0,0,32'h0,                 1,0,2'b11,2'b10,32'h0,2'b00,32'h0});
    vecs.push_back('{1,0,2'd1,B+32'h1,32'h0,0,32'h0,                 1,0,2'b11,2'b10,32'h0,2'b00,32'h0});
    vecs.push_back('{1,0,2'd2,B+32'h2000,32'h0,0,32'h0,              1,0,2'b11,2'b10,32'h0,2'b00,32'h0});
    vecs.push_back('{1,0,2'd2,B-32'h4,32'h0,0,32'h0,                 1,0,2'b11,2'b10,32'h0,2'b00,32'h0});
    vecs.push_back('{0,0,2'd2,32'h0,32'h0,1,B+32'h2,                 0,1,2'b11,2'b00,32'h0,2'b10,32'h0});
    vecs.push_back('{1,1,2'd2,B+32'h4,32'hCAFE_F00D,1,B+32'h10,      1,1,2'b00,2'b01,32'h0,2'b01,32'hDEAD_BEEF});
    vecs.push_back('{1,1,2'd0,B+32'h4,32'h0000_005A,1,B+32'h20,      1,1,2'b00,2'b01,32'h0,2'b01,32'h7788_3344});
    vecs.push_back('{1,1,2'd1,B+32'h6,32'h0000_1234,1,B+32'h1,       1,1,2'b01,2'b01,32'h0,2'b10,32'h0});
    vecs.push_back('{1,0,2'd2,B+32'h4,32'h0,1,B+32'h18,              1,1,2'b00,2'b01,32'h1234_F05A,2'b01,32'h0});

    idle();
    rst = 1;
    imem_req = 1; imem_addr = B; dmem_req = 1; dmem_addr = B + 32'h4;
    step(); step(); #1;
    chk("rst_iack", 32'(imem_req_ack), 32'h0);
    chk("rst_dack", 32'(dmem_req_ack), 32'h0);
    chk("rst_iresp", 32'(imem_resp), 32'h0);
    chk("rst_dresp", 32'(dmem_resp), 32'h0);
    chk("rst_csb", 32'(sram_csb), 32'h3);
    chk("rst_web", 32'(sram_web), 32'h3);
    chk("rst_rdata", imem_rdata | dmem_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    idle();

    for (int v = 0; v < vecs.size(); v++) begin
      dmem_req = vecs[v].d_req; dmem_cmd = vecs[v].d_cmd; dmem_width = vecs[v].d_w;
      dmem_addr = vecs[v].d_addr; dmem_wdata = vecs[v].d_wdata;
      imem_req = vecs[v].i_req; imem_addr = vecs[v].i_addr;
      #1;
      chk($sformatf("v%0d_dack", v), 32'(dmem_req_ack), 32'(vecs[v].e_dack));
      chk($sformatf("v%0d_iack", v), 32'(imem_req_ack), 32'(vecs[v].e_iack));
      chk($sformatf("v%0d_csb", v), 32'(sram_csb), 32'(vecs[v].e_csb));
      step();
      idle();
      chk($sformatf("v%0d_dresp", v), 32'(dmem_resp), 32'(vecs[v].e_dresp));
      chk($sformatf("v%0d_drdata", v), dmem_rdata, vecs[v].e_drdata);
      chk($sformatf("v%0d_iresp", v), 32'(imem_resp), 32'(vecs[v].e_iresp));
      chk($sformatf("v%0d_irdata", v), imem_rdata, vecs[v].e_irdata);
      $display("vec %0d: d_addr=%h i_addr=%h dresp=%b drdata=%h iresp=%b irdata=%h",
               v, vecs[v].d_addr, vecs[v].i_addr, dmem_resp, dmem_rdata, imem_resp, imem_rdata);
      #1;
    end

    // Same-bank conflicts: dmem wins first, then imem, then flag returns.
    for (int r = 0; r < 2; r++) begin
      imem_req = 1; imem_addr = B; dmem_req = 1; dmem_addr = B + 32'h8;
      #1;
      chk($sformatf("cf%0d_dack", r), 32'(dmem_req_ack), (r == 0) ? 32'h1 : 32'h0);
      chk($sformatf("cf%0d_iack", r), 32'(imem_req_ack), (r == 0) ? 32'h0 : 32'h1);
      step();
      if (r == 0) dmem_req = 0; else imem_req = 0;
      #1;
      chk($sformatf("cf%0d_loser_ack", r),
          32'(r == 0 ? imem_req_ack : dmem_req_ack), 32'h1);
      chk($sformatf("cf%0d_winner_resp", r),
          32'(r == 0 ? dmem_resp : imem_resp), 32'h1);
      step();
      chk($sformatf("cf%0d_loser_resp", r),
          32'(r == 0 ? imem_resp : dmem_resp), 32'h1);
      $display("conflict round %0d done", r);
      idle();
    end
    imem_req = 1; imem_addr = B; dmem_req = 1; dmem_addr = B + 32'h4;
    #1;
    chk("diffbank_ack", {30'h0, imem_req_ack, dmem_req_ack}, 32'h3);
    step();
    idle();
    chk("diffbank_resp", {28'h0, imem_resp, dmem_resp}, 32'h5);
    $display("different-bank pair done");

    // Back-to-back dmem writes then imem reads of 8 consecutive words.
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) chk($sformatf("bw%0d_resp", k - 1), 32'(dmem_resp), 32'h1);
      if (k < 8) begin
        dmem_req = 1; dmem_cmd = 1; dmem_width = 2'b10;
        dmem_addr = B + 32'h40 + 32'(4 * k); dmem_wdata = 32'h1000_0000 + 32'(k * 32'h111);
        #1;
        chk($sformatf("bw%0d_ack", k), 32'(dmem_req_ack), 32'h1);
        step();
      end
    end
    idle();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk($sformatf("br%0d_resp", k - 1), 32'(imem_resp), 32'h1);
        chk($sformatf("br%0d_data", k - 1), imem_rdata, 32'h1000_0000 + 32'((k - 1) * 32'h111));
        $display("stream read %0d: resp=%b data=%h", k - 1, imem_resp, imem_rdata);
      end
      if (k < 8) begin
        imem_req = 1; imem_addr = B + 32'h40 + 32'(4 * k);
        #1;
        chk($sformatf("br%0d_ack", k), 32'(imem_req_ack), 32'h1);
        step();
      end
    end
    idle();

    // Reset right after an accepted read suppresses its response.
    dmem_req = 1; dmem_cmd = 0; dmem_addr = B + 32'h10;
    #1;
    chk("rr_ack", 32'(dmem_req_ack), 32'h1);
    step();
    rst = 1;
    #1;
    chk("rr_resp_suppressed", 32'(dmem_resp), 32'h0);
    chk("rr_rdata", dmem_rdata, 32'h0);
    chk("rr_csb", 32'(sram_csb), 32'h3);
    chk("rr_ack_in_rst", 32'(dmem_req_ack), 32'h0);
    step();
    rst = 0;
    #1;
    chk("rr_resp_after", 32'(dmem_resp), 32'h0);
    chk("rr_post_ack", 32'(dmem_req_ack), 32'h1);
    step();
    idle();
    chk("rr_post_resp", 32'(dmem_resp), 32'h1);
    chk("rr_post_data", dmem_rdata, 32'hDEAD_BEEF);
    $display("reset-in-flight sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
